// File: rtl/volume_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | volume_pkg                                                       |
// | Shared constants for the volume ramp controller.                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package volume_pkg;

    localparam logic [1:0] RAMP_IDLE = 2'd0;
    localparam logic [1:0] RAMP_UP   = 2'd1;
    localparam logic [1:0] RAMP_DOWN = 2'd2;

    localparam logic MODE_BTN  = 1'b0;
    localparam logic MODE_KNOB = 1'b1;

    localparam int DEF_LVL_W     = 4;
    localparam int DEF_AMP_W     = 16;
    localparam int DEF_ADC_W     = 16;
    localparam int DEF_AMP_STEP  = 16;
    localparam int DEF_DEF_LEVEL = 1;
    localparam int DEF_KNOB_HOLD = 3;
    localparam int DEF_RAMP_DIV  = 1000;
    localparam int DEF_RAMP_STEP = 1;

endpackage
`default_nettype wire

// File: rtl/vol_ramp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vol_ramp                                                         |
// | Slew limiter: walks volume toward target in bounded tick steps.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module vol_ramp
    import volume_pkg::*;
#(
    parameter int AMP_W     = DEF_AMP_W,
    parameter int RAMP_DIV  = DEF_RAMP_DIV,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AMP_W-1:0] target,
    output logic [AMP_W-1:0] volume,
    output logic             ramping
);

    localparam int                 C_PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [C_PRE_W-1:0] C_PRE_LAST = C_PRE_W'(RAMP_DIV - 1);
    localparam logic [AMP_W:0]     C_STEP     = (AMP_W + 1)'(RAMP_STEP);

    if (RAMP_DIV < 1) begin : g_div_chk
        $error("vol_ramp: RAMP_DIV must be >= 1");
    end
    if (RAMP_STEP < 1) begin : g_step_chk
        $error("vol_ramp: RAMP_STEP must be >= 1");
    end

    logic [C_PRE_W-1:0] pre_q, pre_d;
    logic [AMP_W-1:0]   vol_q, vol_d;
    logic [1:0]         w_state;
    logic [AMP_W:0]     w_gap;
    logic               w_tick;

    always_comb begin
        w_tick = (pre_q == C_PRE_LAST);
        pre_d  = w_tick ? '0 : pre_q + 1'b1;

        // Direction is re-evaluated every cycle, so a target change redirects the next tick.
        if (vol_q < target) begin
            w_state = RAMP_UP;
            w_gap   = {1'b0, target - vol_q};
        end else if (vol_q > target) begin
            w_state = RAMP_DOWN;
            w_gap   = {1'b0, vol_q - target};
        end else begin
            w_state = RAMP_IDLE;
            w_gap   = '0;
        end

        vol_d = vol_q;
        if (w_tick) begin
            case (w_state)
                RAMP_UP:   vol_d = (w_gap <= C_STEP) ? target : vol_q + C_STEP[AMP_W-1:0];
                RAMP_DOWN: vol_d = (w_gap <= C_STEP) ? target : vol_q - C_STEP[AMP_W-1:0];
                default:   vol_d = vol_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            vol_q <= '0;
        end else begin
            pre_q <= pre_d;
            vol_q <= vol_d;
        end
    end

    assign volume  = vol_q;
    assign ramping = (w_state != RAMP_IDLE);

endmodule
`default_nettype wire

// File: rtl/volume_ramp_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | volume_ramp_ctrl                                                 |
// | Button/ADC level select with mute, feeding a click-free ramp.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module volume_ramp_ctrl
    import volume_pkg::*;
#(
    parameter int LVL_W     = DEF_LVL_W,
    parameter int AMP_W     = DEF_AMP_W,
    parameter int ADC_W     = DEF_ADC_W,
    parameter int AMP_STEP  = DEF_AMP_STEP,
    parameter int DEF_LEVEL = DEF_DEF_LEVEL,
    parameter int KNOB_HOLD = DEF_KNOB_HOLD,
    parameter int RAMP_DIV  = DEF_RAMP_DIV,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             up,
    input  logic             down,
    input  logic             mute_tgl,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic [LVL_W-1:0] level,
    output logic [AMP_W-1:0] volume,
    output logic             muted,
    output logic             ramping
);

    localparam int                 LEVELS      = 2 ** LVL_W;
    localparam int                 C_HOLD_W    = $clog2(KNOB_HOLD + 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD     = C_HOLD_W'(KNOB_HOLD);
    localparam logic [LVL_W-1:0]   C_LVL_MAX   = '1;
    localparam logic [LVL_W-1:0]   C_LVL_RST   = LVL_W'(DEF_LEVEL);
    localparam logic [AMP_W-1:0]   C_AMP_STEP  = AMP_W'(AMP_STEP);

    if (64'(AMP_STEP) * 64'(LEVELS - 1) >= (64'd1 << AMP_W)) begin : g_amp_chk
        $error("volume_ramp_ctrl: AMP_STEP*(LEVELS-1) does not fit AMP_W");
    end
    if (ADC_W < LVL_W) begin : g_adc_chk
        $error("volume_ramp_ctrl: ADC_W must be >= LVL_W");
    end
    if (KNOB_HOLD < 1) begin : g_hold_chk
        $error("volume_ramp_ctrl: KNOB_HOLD must be >= 1");
    end

    logic                up_q, up_d, down_q, down_d, mute_q, mute_d, mode_q, mode_d;
    logic                muted_q, muted_d;
    logic [LVL_W-1:0]    level_q, level_d, cand_q, cand_d;
    logic [C_HOLD_W-1:0] hold_q, hold_d;

    logic                w_up_rise, w_down_rise, w_mute_rise, w_mode_chg;
    logic [LVL_W-1:0]    w_cand;
    logic [C_HOLD_W-1:0] w_hold_next;
    logic [AMP_W-1:0]    w_target;
    logic                w_adc_unused;

    // Only the top LVL_W bits of a sample select a level.
    assign w_adc_unused = ^adc_data;

    always_comb begin
        w_up_rise   = up & ~up_q;
        w_down_rise = down & ~down_q;
        w_mute_rise = mute_tgl & ~mute_q;
        w_mode_chg  = (mode != mode_q);
        w_cand      = adc_data[ADC_W-1 -: LVL_W];
        w_hold_next = '0;

        up_d    = up;
        down_d  = down;
        mute_d  = mute_tgl;
        mode_d  = mode;
        muted_d = muted_q ^ w_mute_rise;
        level_d = level_q;
        cand_d  = cand_q;
        hold_d  = hold_q;

        if (mode == MODE_BTN) begin
            if (w_up_rise && !w_down_rise && level_q != C_LVL_MAX) begin
                level_d = level_q + 1'b1;
            end else if (w_down_rise && !w_up_rise && level_q != '0) begin
                level_d = level_q - 1'b1;
            end
        end

        if (w_mode_chg) begin
            hold_d = '0;
        end else if (mode == MODE_KNOB && adc_valid) begin
            if (w_cand == level_q) begin
                hold_d = '0;
            end else begin
                w_hold_next = (w_cand == cand_q) ? hold_q + 1'b1 : C_HOLD_W'(1);
                cand_d      = w_cand;
                if (w_hold_next >= C_HOLD) begin
                    level_d = w_cand;
                    hold_d  = '0;
                end else begin
                    hold_d  = w_hold_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            mute_q  <= 1'b0;
            mode_q  <= 1'b0;
            muted_q <= 1'b0;
            level_q <= C_LVL_RST;
            cand_q  <= '0;
            hold_q  <= '0;
        end else begin
            up_q    <= up_d;
            down_q  <= down_d;
            mute_q  <= mute_d;
            mode_q  <= mode_d;
            muted_q <= muted_d;
            level_q <= level_d;
            cand_q  <= cand_d;
            hold_q  <= hold_d;
        end
    end

    assign w_target = muted_q ? '0 : AMP_W'(level_q) * C_AMP_STEP;

    vol_ramp #(
        .AMP_W     (AMP_W),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP)
    ) u_vol_ramp (
        .clk     (clk),
        .rst     (rst),
        .target  (w_target),
        .volume  (volume),
        .ramping (ramping)
    );

    assign level = level_q;
    assign muted = muted_q;

endmodule
`default_nettype wire

// File: tb/tb_volume_ramp_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_volume_ramp_ctrl                                              |
// | Directed + randomized bench against a behavioural volume model.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_volume_ramp_ctrl;

    localparam int LVL_W     = 4;
    localparam int AMP_W     = 16;
    localparam int ADC_W     = 16;
    localparam int AMP_STEP  = 16;
    localparam int DEF_LEVEL = 1;
    localparam int KNOB_HOLD = 3;
    localparam int RAMP_DIV  = 4;
    localparam int RAMP_STEP = 8;
    localparam int MAX_LVL   = 2 ** LVL_W - 1;

    logic             clk, rst, mode, up, down, mute_tgl, adc_valid;
    logic [ADC_W-1:0] adc_data;
    logic [LVL_W-1:0] level;
    logic [AMP_W-1:0] volume;
    logic             muted, ramping;

    int checks   = 0;
    int failures = 0;

    // Reference model state, kept as plain integers.
    int m_level, m_muted, m_vol, m_pre, m_cnt, m_cand;
    int p_up, p_down, p_mute, p_mode;

    volume_ramp_ctrl #(
        .LVL_W(LVL_W), .AMP_W(AMP_W), .ADC_W(ADC_W), .AMP_STEP(AMP_STEP),
        .DEF_LEVEL(DEF_LEVEL), .KNOB_HOLD(KNOB_HOLD), .RAMP_DIV(RAMP_DIV),
        .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .up(up), .down(down),
        .mute_tgl(mute_tgl), .adc_valid(adc_valid), .adc_data(adc_data),
        .level(level), .volume(volume), .muted(muted), .ramping(ramping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int target_of(input int lvl, input int mtd);
        return mtd ? 0 : lvl * AMP_STEP;
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        int tgt, c;
        bit upr, dnr;
        @(posedge clk);
        if (rst) begin
            m_level = DEF_LEVEL; m_muted = 0; m_vol = 0; m_pre = 0; m_cnt = 0; m_cand = 0;
            p_up = 0; p_down = 0; p_mute = 0; p_mode = 0;
        end else begin
            tgt = target_of(m_level, m_muted);
            if (m_pre == RAMP_DIV - 1) begin
                if (m_vol < tgt)      m_vol += (tgt - m_vol < RAMP_STEP) ? tgt - m_vol : RAMP_STEP;
                else if (m_vol > tgt) m_vol -= (m_vol - tgt < RAMP_STEP) ? m_vol - tgt : RAMP_STEP;
            end
            m_pre = (m_pre + 1) % RAMP_DIV;
            if (mute_tgl && !p_mute) m_muted = !m_muted;
            upr = up && !p_up;
            dnr = down && !p_down;
            if (mode == 1'b0) begin
                if (upr && !dnr)      m_level = (m_level < MAX_LVL) ? m_level + 1 : MAX_LVL;
                else if (dnr && !upr) m_level = (m_level > 0) ? m_level - 1 : 0;
            end
            if (int'(mode) != p_mode) begin
                m_cnt = 0;
            end else if (mode == 1'b1 && adc_valid) begin
                c = int'(adc_data) >> (ADC_W - LVL_W);
                if (c == m_level) begin
                    m_cnt = 0;
                end else begin
                    m_cnt  = (c == m_cand) ? m_cnt + 1 : 1;
                    m_cand = c;
                    if (m_cnt >= KNOB_HOLD) begin
                        m_level = c;
                        m_cnt   = 0;
                    end
                end
            end
            p_up = up; p_down = down; p_mute = mute_tgl; p_mode = mode;
        end
        #1;
        check("level", level, m_level);
        check("volume", volume, m_vol);
        check("muted", muted, m_muted);
        if (!rst) check("ramping", ramping, m_vol != target_of(m_level, m_muted));
    endtask

    task automatic strobe(input logic [ADC_W-1:0] d);
        adc_valid = 1'b1; adc_data = d; step();
        adc_valid = 1'b0; step();
    endtask

    task automatic pulse_up();   up = 1'b1; step(); up = 1'b0; step(); endtask
    task automatic pulse_down(); down = 1'b1; step(); down = 1'b0; step(); endtask
    task automatic pulse_mute(); mute_tgl = 1'b1; step(); mute_tgl = 1'b0; step(); endtask

    initial begin
        int pv;
        rst = 1'b1; mode = 1'b0; up = 1'b0; down = 1'b0; mute_tgl = 1'b0;
        adc_valid = 1'b0; adc_data = '0;
        step(); step();
        check("rst_level", level, 1);
        check("rst_volume", volume, 0);
        check("rst_muted", muted, 0);

        // Ramp from reset: one 8-step tick every 4 cycles.
        rst = 1'b0;
        repeat (3) step();
        check("t1_vol_c3", volume, 0);
        check("t1_ramping_c3", ramping, 1);
        step();
        check("t1_vol_c4", volume, 8);
        repeat (4) step();
        check("t1_vol_c8", volume, 16);
        check("t1_ramping_c8", ramping, 0);

        // Buttons: saturation, simultaneous rise, held input.
        repeat (20) pulse_up();
        repeat (150) step();
        check("t2_level_sat", level, 15);
        check("t2_vol_240", volume, 240);
        pulse_down();
        check("t2_level_dn", level, 14);
        up = 1'b1; down = 1'b1; step();
        up = 1'b0; down = 1'b0; step();
        check("t2_both", level, 14);
        up = 1'b1; repeat (50) step();
        up = 1'b0; step();
        check("t2_hold_up", level, 15);

        // ADC mode: three agreeing samples, alternating samples, inactive source.
        mode = 1'b1; step(); step();
        strobe(16'h7000);
        check("t3_s1", level, 15);
        strobe(16'h7000);
        check("t3_s2", level, 15);
        strobe(16'h7000);
        check("t3_s3", level, 7);
        repeat (3) begin strobe(16'h3000); strobe(16'h8000); end
        check("t3_alt", level, 7);
        mode = 1'b0; step();
        repeat (3) strobe(16'h2000);
        check("t3_btn_ignores_adc", level, 7);
        repeat (100) step();
        check("t3_vol_112", volume, 112);

        // Mute mid-ramp reverses direction; unmute returns to full level.
        repeat (8) pulse_up();
        for (int i = 0; i < 200 && volume != 176; i++) step();
        check("t4_reach_176", volume, 176);
        pulse_mute();
        for (int i = 0; i < 400 && volume != 0; i++) begin
            pv = volume;
            step();
            if (volume != pv) check("t4_dec_step", pv - volume, 8);
        end
        check("t4_vol_0", volume, 0);
        check("t4_muted", muted, 1);
        pulse_mute();
        for (int i = 0; i < 400 && volume != 240; i++) step();
        check("t4_vol_240", volume, 240);
        check("t4_unmuted", muted, 0);

        // Reset mid-ramp.
        pulse_mute();
        for (int i = 0; i < 200 && volume != 200; i++) step();
        check("t5_reach_200", volume, 200);
        rst = 1'b1; step();
        check("t5_vol", volume, 0);
        check("t5_level", level, 1);
        check("t5_muted", muted, 0);
        rst = 1'b0; step();

        // Mode switch clears a pending hold count.
        mode = 1'b1; step();
        strobe(16'h5000);
        strobe(16'h5000);
        mode = 1'b0; step();
        mode = 1'b1; step();
        strobe(16'h5000);
        check("t6_level_kept", level, 1);
        strobe(16'h5000);
        strobe(16'h5000);

        // Randomized traffic, compared against the model every cycle.
        for (int i = 0; i < 1500; i++) begin
            logic nm;
            nm        = ($urandom_range(0, 39) == 0) ? ~mode : mode;
            up        = ($urandom_range(0, 5) == 0);
            down      = ($urandom_range(0, 6) == 0);
            mute_tgl  = ($urandom_range(0, 30) == 0);
            adc_valid = (nm == mode) && ($urandom_range(0, 1) == 1);
            adc_data  = {4'($urandom_range(4, 7)), 12'($urandom)};
            rst       = ($urandom_range(0, 299) == 0);
            mode      = nm;
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
